// File: rtl/imgbuf_pkg.sv
// -----------------------------------------------------------------------------
// imgbuf_pkg
// Shared definitions for the 100x75 image buffer and its read-port arbiter:
// image geometry, buffer address/data widths and the read tag that travels
// alongside each outstanding buffer read.
// -----------------------------------------------------------------------------
package imgbuf_pkg;

    localparam int IMG_W   = 100;
    localparam int IMG_H   = 75;
    localparam int IMG_LEN = IMG_W * IMG_H;   // 7500 pixels
    localparam int AW      = 13;              // ceil(log2(7500))
    localparam int DW      = 8;

    // Requester indices.
    localparam logic IDX0 = 1'b0;
    localparam logic IDX1 = 1'b1;

    // One tag per buffer read: whether a read was issued and for whom.
    typedef struct packed {
        logic valid;
        logic idx;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, idx: IDX0};

endpackage

// File: rtl/imgbuf_arbiter_if.sv
// -----------------------------------------------------------------------------
// imgbuf_arbiter_if
// Bundles the two requester ports, the buffer read port and the arbiter
// status into one interface.
//   slave  : arbiter view (takes requests and buffer data, drives grants,
//            buffer address/enable, returned data and owner)
//   master : environment view (requesters plus the buffer itself)
// Optional feature macro IMGBUF_ARB_STATS_EN adds stats_clr, gcnt0, gcnt1.
// -----------------------------------------------------------------------------
interface imgbuf_arbiter_if #(
    parameter int AW = imgbuf_pkg::AW,
    parameter int DW = imgbuf_pkg::DW
);
    // Requester 0 (downsampler address stream)
    logic          req0;
    logic          lock0;
    logic [AW-1:0] addr0;
    logic          gnt0;
    logic          rvalid0;
    // Requester 1 (display scan / debug dump)
    logic          req1;
    logic          lock1;
    logic [AW-1:0] addr1;
    logic          gnt1;
    logic          rvalid1;
    // Buffer read port
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    // Shared return data and arbiter state
    logic [DW-1:0] rdata;
    logic          owner;
`ifdef IMGBUF_ARB_STATS_EN
    logic          stats_clr;
    logic [15:0]   gcnt0;
    logic [15:0]   gcnt1;

    modport slave (
        input  req0, lock0, addr0, req1, lock1, addr1, mem_rdata, stats_clr,
        output gnt0, rvalid0, gnt1, rvalid1, mem_en, mem_addr, rdata, owner,
               gcnt0, gcnt1
    );
    modport master (
        output req0, lock0, addr0, req1, lock1, addr1, mem_rdata, stats_clr,
        input  gnt0, rvalid0, gnt1, rvalid1, mem_en, mem_addr, rdata, owner,
               gcnt0, gcnt1
    );
`else
    modport slave (
        input  req0, lock0, addr0, req1, lock1, addr1, mem_rdata,
        output gnt0, rvalid0, gnt1, rvalid1, mem_en, mem_addr, rdata, owner
    );
    modport master (
        output req0, lock0, addr0, req1, lock1, addr1, mem_rdata,
        input  gnt0, rvalid0, gnt1, rvalid1, mem_en, mem_addr, rdata, owner
    );
`endif
endinterface

// File: rtl/imgbuf_tag_pipe.sv
// -----------------------------------------------------------------------------
// imgbuf_tag_pipe
// DEPTH-stage shift register of read tags that mirrors the buffer read
// latency, so the tag leaving the last stage lines up with mem_rdata.
// Synchronous clear drops every in-flight tag.
// Ports:
//   clk      clock
//   rst      synchronous active-high clear of all stages
//   tag_in   tag of the read issued this cycle (valid=0 when idle)
//   tag_out  tag of the read whose data is on mem_rdata this cycle
// -----------------------------------------------------------------------------
module imgbuf_tag_pipe
    import imgbuf_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t [DEPTH-1:0] stage_reg;
    tag_t [DEPTH-1:0] stage_next;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign stage_next[gi] = tag_in;
        end else begin : g_body
            assign stage_next[gi] = stage_reg[gi-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_reg <= {DEPTH{TAG_IDLE}};
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/imgbuf_arbiter.sv
// -----------------------------------------------------------------------------
// imgbuf_arbiter
// Shares the single read port of the 7500x8 image buffer between two
// requesters. Round-robin between simultaneous requests, with an optional
// per-requester lock that lets the current owner keep the port for up to
// MAX_HOLD consecutive grants while the other side waits. Each grant issues
// one buffer read; the data comes back RD_LAT cycles later on the shared
// rdata bus with rvalid0/rvalid1 identifying the recipient.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   imgbuf_arbiter_if.slave:
//         req/lock/addr/gnt/rvalid per requester, mem_en/mem_addr/mem_rdata
//         to the buffer, rdata (shared return data), owner (last granted).
// Optional feature macro IMGBUF_ARB_STATS_EN: per-requester 16-bit saturating
// grant counters gcnt0/gcnt1, cleared by rst or stats_clr.
// -----------------------------------------------------------------------------
module imgbuf_arbiter #(
    parameter int AW       = imgbuf_pkg::AW,
    parameter int DW       = imgbuf_pkg::DW,
    parameter int RD_LAT   = 1,          // 1..4
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    imgbuf_arbiter_if.slave bus
);
    import imgbuf_pkg::*;

    localparam int             HW        = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);

    // ---------------------------------------------------------------- state
    logic          owner_reg;
    logic [HW-1:0] hold_cnt_reg;

    // ---------------------------------------------------------- arbitration
    logic          gnt_any;
    logic          gnt_idx;
    logic          owner_lock;
    logic [AW-1:0] mem_addr_w;

    always_comb begin
        owner_lock = owner_reg ? bus.lock1 : bus.lock0;
        gnt_any    = bus.req0 | bus.req1;
        gnt_idx    = IDX0;
        if (bus.req0 && bus.req1) begin
            // Contention: the owner keeps the port only while locked and
            // still inside its hold budget; otherwise the other side wins.
            if (owner_lock && (hold_cnt_reg < HOLD_LAST)) begin
                gnt_idx = owner_reg;
            end else begin
                gnt_idx = ~owner_reg;
            end
        end else begin
            gnt_idx = bus.req1;
        end
    end

    always_comb begin
        mem_addr_w = '0;
        if (gnt_any) begin
            mem_addr_w = gnt_idx ? bus.addr1 : bus.addr0;
        end
    end

    assign bus.gnt0     = gnt_any & ~gnt_idx;
    assign bus.gnt1     = gnt_any &  gnt_idx;
    assign bus.mem_en   = gnt_any;
    assign bus.mem_addr = mem_addr_w;
    assign bus.owner    = owner_reg;

    // owner starts at 1 so requester 0 wins the first contended cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg    <= IDX1;
            hold_cnt_reg <= '0;
        end else if (gnt_any) begin
            owner_reg <= gnt_idx;
            if (gnt_idx != owner_reg) begin
                hold_cnt_reg <= '0;
            end else if (hold_cnt_reg != HOLD_LAST) begin
                hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------- return routing
    tag_t tag_in_w;
    tag_t tag_out_w;

    always_comb begin
        tag_in_w       = TAG_IDLE;
        tag_in_w.valid = gnt_any;
        tag_in_w.idx   = gnt_idx;
    end

    imgbuf_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in_w),
        .tag_out (tag_out_w)
    );

    // Buffer data is forwarded unregistered; only the tag is pipelined.
    logic [DW-1:0] rdata_w;
    assign rdata_w     = bus.mem_rdata;
    assign bus.rdata   = rdata_w;
    assign bus.rvalid0 = tag_out_w.valid & (tag_out_w.idx == IDX0);
    assign bus.rvalid1 = tag_out_w.valid & (tag_out_w.idx == IDX1);

`ifdef IMGBUF_ARB_STATS_EN
    // ------------------------------------------------------ grant counters
    logic [1:0]        gnt_vec;
    logic [1:0][15:0]  gcnt_w;

    assign gnt_vec = {bus.gnt1, bus.gnt0};

    for (genvar gi = 0; gi < 2; gi++) begin : g_stats
        logic [15:0] cnt_reg;

        always_ff @(posedge clk) begin
            if (rst || bus.stats_clr) begin
                cnt_reg <= '0;
            end else if (gnt_vec[gi] && (cnt_reg != 16'hFFFF)) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end

        assign gcnt_w[gi] = cnt_reg;
    end

    assign bus.gcnt0 = gcnt_w[0];
    assign bus.gcnt1 = gcnt_w[1];
`endif

endmodule

// File: tb/tb_imgbuf_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imgbuf_arbiter
// Two arbiter instances share one stimulus stream: instance 0 with RD_LAT=1,
// MAX_HOLD=4 and instance 1 with RD_LAT=3, MAX_HOLD=16. A reference model
// tracks owner and the length of the current grant streak, and remembers every
// grant so the expected response is the grant issued RD_LAT cycles earlier.
// A small buffer model returns pix(addr) RD_LAT cycles after each read.
// Build with IMGBUF_ARB_STATS_EN to include the grant-counter scenario.
// -----------------------------------------------------------------------------
module tb_imgbuf_arbiter;
    import imgbuf_pkg::*;

    localparam int LAT_A  = 1;
    localparam int HOLD_A = 4;
    localparam int LAT_B  = 3;
    localparam int HOLD_B = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req0, req1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
`ifdef IMGBUF_ARB_STATS_EN
    logic          stats_clr;
`endif

    imgbuf_arbiter_if #(.AW(AW), .DW(DW)) bus_a ();
    imgbuf_arbiter_if #(.AW(AW), .DW(DW)) bus_b ();

    assign bus_a.req0 = req0;   assign bus_b.req0 = req0;
    assign bus_a.req1 = req1;   assign bus_b.req1 = req1;
    assign bus_a.lock0 = lock0; assign bus_b.lock0 = lock0;
    assign bus_a.lock1 = lock1; assign bus_b.lock1 = lock1;
    assign bus_a.addr0 = addr0; assign bus_b.addr0 = addr0;
    assign bus_a.addr1 = addr1; assign bus_b.addr1 = addr1;
`ifdef IMGBUF_ARB_STATS_EN
    assign bus_a.stats_clr = stats_clr;
    assign bus_b.stats_clr = stats_clr;
`endif

    imgbuf_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT_A), .MAX_HOLD(HOLD_A)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    imgbuf_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT_B), .MAX_HOLD(HOLD_B)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    // ------------------------------------------------------- buffer model
    function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
        return a[7:0] ^ {a[12:8], 3'b101};
    endfunction

    logic [AW-1:0] pa_a [4];
    logic [AW-1:0] pa_b [4];
    always @(posedge clk) begin
        pa_a[0] <= bus_a.mem_addr;
        pa_b[0] <= bus_b.mem_addr;
        for (int i = 1; i < 4; i++) begin
            pa_a[i] <= pa_a[i-1];
            pa_b[i] <= pa_b[i-1];
        end
    end
    assign bus_a.mem_rdata = pix(pa_a[LAT_A-1]);
    assign bus_b.mem_rdata = pix(pa_b[LAT_B-1]);

    // Observed vector: {gnt0, gnt1, mem_en, mem_addr, rvalid0, rvalid1, owner}
    logic [18:0]   obs_vec   [2];
    logic [DW-1:0] obs_rdata [2];
    assign obs_vec[0] = {bus_a.gnt0, bus_a.gnt1, bus_a.mem_en, bus_a.mem_addr,
                         bus_a.rvalid0, bus_a.rvalid1, bus_a.owner};
    assign obs_vec[1] = {bus_b.gnt0, bus_b.gnt1, bus_b.mem_en, bus_b.mem_addr,
                         bus_b.rvalid0, bus_b.rvalid1, bus_b.owner};
    assign obs_rdata[0] = bus_a.rdata;
    assign obs_rdata[1] = bus_b.rdata;

    // ---------------------------------------------------- reference model
    int            m_owner  [2];
    int            m_streak [2];   // consecutive grants to the current owner
    int            m_g      [2];   // grant this cycle: -1 none, else index
    bit            h_v      [2][8];
    bit            h_idx    [2][8];
    logic [AW-1:0] h_addr   [2][8];
    logic [18:0]   exp_vec  [2];
    logic [DW-1:0] exp_rdata[2];
    bit            exp_rv   [2];
    int            cyc;
    bit            armed;
    int            n_checks;
    int            n_errors;

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic int hold_of(input int k);
        return (k == 0) ? HOLD_A : HOLD_B;
    endfunction

    function automatic void model_eval();
        for (int k = 0; k < 2; k++) begin
            int            g;
            int            slot;
            bit            lk;
            logic [AW-1:0] ga;
            g = -1;
            if (req0 && req1) begin
                lk = (m_owner[k] == 1) ? lock1 : lock0;
                g  = (lk && m_streak[k] < hold_of(k)) ? m_owner[k] : 1 - m_owner[k];
            end else if (req0) begin
                g = 0;
            end else if (req1) begin
                g = 1;
            end
            m_g[k] = g;
            ga     = (g == 0) ? addr0 : (g == 1) ? addr1 : '0;
            slot   = (cyc + 8 - lat_of(k)) % 8;
            exp_rv[k]    = h_v[k][slot];
            exp_rdata[k] = pix(h_addr[k][slot]);
            exp_vec[k]   = {g == 0, g == 1, g >= 0, ga,
                            h_v[k][slot] && !h_idx[k][slot],
                            h_v[k][slot] && h_idx[k][slot],
                            m_owner[k] == 1};
        end
    endfunction

    task automatic drive(input bit r, input bit q0, input bit q1, input bit l0,
                         input bit l1, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rst = r; req0 = q0; req1 = q1; lock0 = l0; lock1 = l1;
        addr0 = a0; addr1 = a1;
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        for (int k = 0; k < 2; k++) begin
            int slot;
            slot = cyc % 8;
            if (rst) begin
                m_owner[k]  = 1;
                m_streak[k] = 1;
                for (int s = 0; s < 8; s++) h_v[k][s] = 1'b0;
            end else begin
                h_v[k][slot]    = (m_g[k] >= 0);
                h_idx[k][slot]  = (m_g[k] == 1);
                h_addr[k][slot] = (m_g[k] == 1) ? addr1 : addr0;
                if (m_g[k] >= 0) begin
                    if (m_g[k] == m_owner[k]) begin
                        m_streak[k]++;
                    end else begin
                        m_owner[k]  = m_g[k];
                        m_streak[k] = 1;
                    end
                end
            end
        end
        if (rst) armed = 1'b1;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] raddr();
        return AW'($urandom_range(0, IMG_LEN - 1));
    endfunction

    // ------------------------------------------------------------- tests
    task automatic test_reset();
        drive(1, 1, 1, 1, 1, raddr(), raddr());
        advance();
        drive(1, 0, 1, 0, 0, raddr(), raddr());
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, raddr(), raddr());
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec[k] !== 19'h00001) begin
                    n_errors++;
                    $display("FAIL reset_state[%0d] cyc %0d: got %h required %h",
                             k, cyc, obs_vec[k], 19'h00001);
                end
                n_checks++;
                if (obs_vec[k] !== exp_vec[k]) begin
                    n_errors++;
                    $display("FAIL reset_model[%0d] cyc %0d: got %h required %h",
                             k, cyc, obs_vec[k], exp_vec[k]);
                end
            end
            advance();
        end
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 10; i++) begin
            bit act;
            act = (i < 6);
            drive(0, act, act, 0, 0, raddr(), raddr());
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec[k] !== exp_vec[k] ||
                    (exp_rv[k] && obs_rdata[k] !== exp_rdata[k])) begin
                    n_errors++;
                    $display("FAIL alternate[%0d] cyc %0d: got %h/%h required %h/%h", k, cyc,
                             obs_vec[k], obs_rdata[k], exp_vec[k], exp_rdata[k]);
                end
                if (act) begin
                    n_checks++;
                    if (obs_vec[k][18] !== (i % 2 == 0)) begin
                        n_errors++;
                        $display("FAIL alternate_gnt0[%0d] step %0d: got %b required %b",
                                 k, i, obs_vec[k][18], (i % 2 == 0));
                    end
                end
            end
            advance();
        end
    endtask

    task automatic test_stream0();
        int n_rv0;
        int n_rv1;
        n_rv0 = 0;
        n_rv1 = 0;
        for (int i = 0; i < 54; i++) begin
            bit act;
            act = (i < 50);
            drive(0, act, 0, $urandom_range(0, 1), $urandom_range(0, 1),
                  AW'(2 * i), raddr());
            if (bus_a.rvalid0) n_rv0++;
            if (bus_a.rvalid1 || bus_a.gnt1) n_rv1++;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec[k] !== exp_vec[k] ||
                    (exp_rv[k] && obs_rdata[k] !== exp_rdata[k])) begin
                    n_errors++;
                    $display("FAIL stream0[%0d] cyc %0d: got %h/%h required %h/%h", k, cyc,
                             obs_vec[k], obs_rdata[k], exp_vec[k], exp_rdata[k]);
                end
            end
            advance();
        end
        n_checks++;
        if (n_rv0 != 50 || n_rv1 != 0) begin
            n_errors++;
            $display("FAIL stream0_count: got rvalid0=%0d port1=%0d required 50/0", n_rv0, n_rv1);
        end
    endtask

    task automatic test_lock_hold();
        drive(1, 0, 0, 0, 0, 0, 0);
        advance();
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 1, 1, 0, raddr(), raddr());
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec[k] !== exp_vec[k] ||
                    (exp_rv[k] && obs_rdata[k] !== exp_rdata[k])) begin
                    n_errors++;
                    $display("FAIL lock_hold[%0d] cyc %0d: got %h/%h required %h/%h", k, cyc,
                             obs_vec[k], obs_rdata[k], exp_vec[k], exp_rdata[k]);
                end
            end
            n_checks++;
            if (bus_a.gnt1 !== (i % 5 == 4)) begin
                n_errors++;
                $display("FAIL lock_hold_pattern step %0d: got gnt1=%b required %b",
                         i, bus_a.gnt1, (i % 5 == 4));
            end
            advance();
        end
    endtask

    task automatic test_lock_drop();
        drive(1, 0, 0, 0, 0, 0, 0);
        advance();
        for (int i = 0; i < 10; i++) begin
            bit q0;
            q0 = (i != 3);
            drive(0, q0, 1, 1, 0, raddr(), raddr());
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec[k] !== exp_vec[k] ||
                    (exp_rv[k] && obs_rdata[k] !== exp_rdata[k])) begin
                    n_errors++;
                    $display("FAIL lock_drop[%0d] cyc %0d: got %h/%h required %h/%h", k, cyc,
                             obs_vec[k], obs_rdata[k], exp_vec[k], exp_rdata[k]);
                end
                if (!q0) begin
                    n_checks++;
                    if (obs_vec[k][17] !== 1'b1) begin
                        n_errors++;
                        $display("FAIL lock_drop_gnt1[%0d]: got %b required 1", k, obs_vec[k][17]);
                    end
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_inflight();
        for (int i = 0; i < 12; i++) begin
            bit r;
            bit act;
            r   = (i == 4);
            act = (i < 5) || (i >= 8);
            drive(r, act, act, 0, 0, raddr(), raddr());
            if (!rst) begin
                for (int k = 0; k < 2; k++) begin
                    n_checks++;
                    if (obs_vec[k] !== exp_vec[k] ||
                        (exp_rv[k] && obs_rdata[k] !== exp_rdata[k])) begin
                        n_errors++;
                        $display("FAIL rst_inflight[%0d] cyc %0d: got %h/%h required %h/%h", k,
                                 cyc, obs_vec[k], obs_rdata[k], exp_vec[k], exp_rdata[k]);
                    end
                    if (i >= 5 && i <= 7) begin
                        n_checks++;
                        if (obs_vec[k][2:1] !== 2'b00) begin
                            n_errors++;
                            $display("FAIL rst_no_rvalid[%0d] step %0d: got %b required 00",
                                     k, i, obs_vec[k][2:1]);
                        end
                    end
                    if (i == 8) begin
                        n_checks++;
                        if (obs_vec[k][18:17] !== 2'b10) begin
                            n_errors++;
                            $display("FAIL rst_first_gnt[%0d]: got %b required 10",
                                     k, obs_vec[k][18:17]);
                        end
                    end
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, raddr(), raddr());
            if (armed && !rst) begin
                for (int k = 0; k < 2; k++) begin
                    n_checks++;
                    if (obs_vec[k] !== exp_vec[k] ||
                        (exp_rv[k] && obs_rdata[k] !== exp_rdata[k])) begin
                        n_errors++;
                        $display("FAIL random[%0d] cyc %0d: got %h/%h required %h/%h", k, cyc,
                                 obs_vec[k], obs_rdata[k], exp_vec[k], exp_rdata[k]);
                    end
                end
            end
            advance();
        end
    endtask

`ifdef IMGBUF_ARB_STATS_EN
    task automatic test_stats();
        stats_clr = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0);
        advance();
        for (int i = 0; i < 70000; i++) begin
            drive(0, 1, 0, 0, 0, raddr(), 0);
            advance();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus_a.gcnt0 !== 16'hFFFF || bus_b.gcnt0 !== 16'hFFFF ||
            bus_a.gcnt1 !== 16'h0 || bus_b.gcnt1 !== 16'h0) begin
            n_errors++;
            $display("FAIL stats_saturate: got %h/%h %h/%h required ffff/ffff 0000/0000",
                     bus_a.gcnt0, bus_b.gcnt0, bus_a.gcnt1, bus_b.gcnt1);
        end
        advance();
        stats_clr = 1'b1;
        drive(0, 1, 0, 0, 0, raddr(), 0);
        advance();
        stats_clr = 1'b0;
        drive(0, 1, 0, 0, 0, raddr(), 0);
        n_checks++;
        if (bus_a.gcnt0 !== 16'h0 || bus_b.gcnt0 !== 16'h0) begin
            n_errors++;
            $display("FAIL stats_clear: got %h/%h required 0000", bus_a.gcnt0, bus_b.gcnt0);
        end
        advance();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus_a.gcnt0 !== 16'h1 || bus_b.gcnt0 !== 16'h1) begin
            n_errors++;
            $display("FAIL stats_restart: got %h/%h required 0001", bus_a.gcnt0, bus_b.gcnt0);
        end
        advance();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        armed    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_owner[k]  = 1;
            m_streak[k] = 1;
            m_g[k]      = -1;
            for (int s = 0; s < 8; s++) begin
                h_v[k][s]    = 1'b0;
                h_idx[k][s]  = 1'b0;
                h_addr[k][s] = '0;
            end
        end
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        addr0 = '0; addr1 = '0;
`ifdef IMGBUF_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        @(posedge clk);
        #1;
        test_reset();
        test_alternate();
        test_stream0();
        test_lock_hold();
        test_lock_drop();
        test_reset_inflight();
        test_random();
`ifdef IMGBUF_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
